dcache_2way: RTL and testbench
==============================

DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameters: LINE_WORDS, default 4, words per line; SET_CNT, default 8, sets; WAY_CNT, fixed 2, ways.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  load request
- wr_en  in  4  per-byte write enables, already lane-aligned
- addr  in  32  byte address
- wr_data  in  32  write data, already lane-aligned
- rd_data  out  32  registered read word
- miss  out  1  stall request to pipeline (combinational)
- mem_rd_req  out  1  line fill request
- mem_wr_req  out  1  line writeback request
- mem_addr  out  32  line-aligned memory address
- mem_wr_line  out  32*LINE_WORDS  writeback line
- mem_rd_line  in  32*LINE_WORDS  fill line
- mem_gnt  in  1  one-cycle completion pulse for current mem request

Function
REQ-003 SHALL decode addr (defaults) as [1:0] byte, [3:2] word, [6:4] set, [31:7] tag; fields SHALL scale with parameters.
REQ-004 SHALL hold per line: valid, dirty, tag, data; and one LRU bit per set naming the least-recently-used way.
REQ-005 SHALL implement FSM states IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
REQ-006 A request SHALL exist when rd_req=1 or wr_en!=0; with no request, FSM SHALL remain in IDLE and miss SHALL be 0.
REQ-007 Hit: a request in IDLE whose tag matches a valid way; miss SHALL be 0 that cycle.
REQ-008 Read hit SHALL load the addressed word into rd_data at the next edge (1-cycle latency); rd_data SHALL hold otherwise.
REQ-009 Write hit SHALL update only the bytes with wr_en set and set dirty; rd_data SHALL be unchanged.
REQ-010 When rd_req and wr_en!=0 are both active, the write SHALL take priority and rd_data SHALL be unchanged.
REQ-011 Every hit SHALL set LRU to the other way.
REQ-012 A request that misses in IDLE, or any request while not in IDLE, SHALL drive miss=1.
REQ-013 Victim selection SHALL be: the first invalid way (way 0 before way 1); otherwise the LRU way.
REQ-014 On miss, IDLE SHALL go to SWAP_OUT if the victim is valid and dirty, else to SWAP_IN.
REQ-015 SWAP_OUT SHALL assert mem_wr_req, with mem_addr={victim tag,set,0} and mem_wr_line=victim data, all held stable until mem_gnt; on mem_gnt SHALL go to SWAP_IN.
REQ-016 SWAP_IN SHALL assert mem_rd_req, with mem_addr={addr tag,set,0} held until mem_gnt; on mem_gnt SHALL capture mem_rd_line into the victim way and go to SWAP_IN_OK.
REQ-017 SWAP_IN_OK SHALL set valid=1, dirty=0, tag=new, LRU=other way, then go to IDLE; the request SHALL then hit normally.
REQ-018 mem_rd_req and mem_wr_req SHALL never be asserted together, and SHALL drop the cycle after mem_gnt.
REQ-019 mem_gnt outside SWAP_OUT/SWAP_IN SHALL be ignored.
REQ-020 Pipeline SHALL hold rd_req, wr_en, addr and wr_data stable while miss=1; behaviour otherwise is undefined.

Reset
REQ-021 rst=1 at an edge SHALL take effect at that edge: state IDLE; all valid, dirty and LRU bits 0; rd_data=0; mem_rd_req=0; mem_wr_req=0; mem_addr=0.
REQ-022 Reset mid-miss (any non-IDLE state) SHALL abort the transaction; dirty data SHALL be discarded.
REQ-023 Data array contents need not be reset.

Verification
REQ-024 Cold read: after reset, rd_req=1, addr=0x10 -> miss=1; mem_rd_req=1 with mem_addr=0x10; gnt after 5 cycles with line {W3,W2,W1,W0} -> SWAP_IN_OK; then miss=0; rd_data=W0 next edge.
REQ-025 Byte write: hit line 0x10, wr_en=0100, wr_data=0x00AB0000 -> read 0x10 returns W0 with bits[23:16]=0xAB and other bytes unchanged; no mem request issued.
REQ-026 Dirty eviction: write 0x10, read 0x90, read 0x110 (all set 1) -> mem_wr_req with mem_addr=0x10 carrying the modified line; after gnt, mem_rd_req with mem_addr=0x110; 0x90 still hits afterwards.
REQ-027 Clean eviction: read 0x10, read 0x90, read 0x10, read 0x110 -> no mem_wr_req; the 0x90 line is replaced; 0x10 still hits.
REQ-028 Reset during SWAP_IN: rst pulse with rd_req=0 -> next cycle mem_rd_req=0, miss=0; re-read of 0x10 misses.
REQ-029 Idle hold: no request for 10 cycles -> miss=0, no mem requests, rd_data unchanged.

Source files
------------

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back data cache with LRU replacement.
// Misses stall the pipeline while a single-line writeback and fill complete.
module dcache_2way #(
    parameter int LINE_WORDS = 4,
    parameter int SET_CNT    = 8,
    parameter int WAY_CNT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [3:0]                 wr_en,
    input  logic [31:0]                addr,
    input  logic [31:0]                wr_data,
    output logic [31:0]                rd_data,
    output logic                       miss,
    output logic                       mem_rd_req,
    output logic                       mem_wr_req,
    output logic [31:0]                mem_addr,
    output logic [32*LINE_WORDS-1:0]   mem_wr_line,
    input  logic [32*LINE_WORDS-1:0]   mem_rd_line,
    input  logic                       mem_gnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int SET_W  = $clog2(SET_CNT);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - OFF_W - SET_W;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } state_t;

    state_t state;

    logic [WAY_CNT-1:0][SET_CNT-1:0] valid_q;
    logic [WAY_CNT-1:0][SET_CNT-1:0] dirty_q;
    logic [SET_CNT-1:0]              lru_q;
    logic [TAG_W-1:0]                tag_q  [WAY_CNT][SET_CNT];
    logic [LINE_W-1:0]               data_q [WAY_CNT][SET_CNT];
    logic                            victim_q;

    logic [TAG_W-1:0]  addr_tag;
    logic [SET_W-1:0]  set_idx;
    logic [WORD_W-1:0] word_idx;
    logic              req;
    logic              wr;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              victim_dirty;
    logic [31:0]       cur_word;
    logic [31:0]       wmerge;
    logic              unused_bits;

    assign addr_tag    = addr[31 -: TAG_W];
    assign set_idx     = addr[OFF_W +: SET_W];
    assign word_idx    = addr[2 +: WORD_W];
    assign unused_bits = ^addr[1:0];

    assign wr   = |wr_en;
    assign req  = rd_req | wr;
    assign hit0 = valid_q[0][set_idx] && (tag_q[0][set_idx] == addr_tag);
    assign hit1 = valid_q[1][set_idx] && (tag_q[1][set_idx] == addr_tag);
    assign hit  = hit0 | hit1;
    assign hit_way = hit1;

    // Fill invalid ways in order before evicting anything.
    assign victim = !valid_q[0][set_idx] ? 1'b0 :
                    !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];
    assign victim_dirty = valid_q[victim][set_idx] && dirty_q[victim][set_idx];

    assign miss = req && ((state != IDLE) || !hit);

    always_comb begin
        cur_word = data_q[hit_way][set_idx][{word_idx, 5'b0} +: 32];
        wmerge   = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_en[b]) wmerge[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_comb begin
        mem_wr_line = '0;
        mem_wr_line = data_q[victim_q][set_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            rd_data    <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            victim_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        lru_q[set_idx] <= ~hit_way;
                        if (wr) dirty_q[hit_way][set_idx] <= 1'b1;
                        else    rd_data <= cur_word;
                    end else if (req) begin
                        victim_q <= victim;
                        if (victim_dirty) begin
                            state      <= SWAP_OUT;
                            mem_wr_req <= 1'b1;
                            mem_addr   <= {tag_q[victim][set_idx], set_idx,
                                           {OFF_W{1'b0}}};
                        end else begin
                            state      <= SWAP_IN;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= {addr_tag, set_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                SWAP_OUT: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN;
                        mem_wr_req <= 1'b0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {addr_tag, set_idx, {OFF_W{1'b0}}};
                    end
                end
                SWAP_IN: begin
                    if (mem_gnt) begin
                        state      <= SWAP_IN_OK;
                        mem_rd_req <= 1'b0;
                    end
                end
                SWAP_IN_OK: begin
                    state                      <= IDLE;
                    valid_q[victim_q][set_idx] <= 1'b1;
                    dirty_q[victim_q][set_idx] <= 1'b0;
                    tag_q[victim_q][set_idx]   <= addr_tag;
                    lru_q[set_idx]             <= ~victim_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data array carries no reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && req && hit && wr)
            data_q[hit_way][set_idx][{word_idx, 5'b0} +: 32] <= wmerge;
        if (!rst && state == SWAP_IN && mem_gnt)
            data_q[victim_q][set_idx] <= mem_rd_line;
    end

endmodule

// File: tb/tb_dcache_2way.sv
// Randomized bench for dcache_2way against a flat-memory plus
// per-set recency model; the bench also plays the memory side.
module tb_dcache_2way;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [3:0]   wr_en;
    logic [31:0]  addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic         miss;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wr_line;
    logic [127:0] mem_rd_line;
    logic         mem_gnt;

    always #5 clk = ~clk;

    dcache_2way dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_en       (wr_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural memory image (gold) and backing store (dram).
    bit [31:0] dram    [bit [31:0]];
    bit [31:0] gold    [bit [31:0]];
    bit        dirty_m [bit [31:0]];
    int        cnt     [8];
    bit [24:0] mru_tag [8];
    bit [24:0] lru_tag [8];
    logic [31:0] exp_rd;

    function automatic bit [31:0] init_w(bit [31:0] k);
        return (k * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit [31:0] gold_rd(bit [31:0] a);
        bit [31:0] k = a >> 2;
        if (gold.exists(k)) return gold[k];
        return init_w(k);
    endfunction

    function automatic bit [31:0] dram_rd(bit [31:0] a);
        bit [31:0] k = a >> 2;
        if (dram.exists(k)) return dram[k];
        return init_w(k);
    endfunction

    function automatic bit [127:0] gold_line(bit [31:0] a);
        bit [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = gold_rd({a[31:4], 4'b0} + 4*w);
        return l;
    endfunction

    function automatic bit [127:0] dram_line(bit [31:0] a);
        bit [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = dram_rd({a[31:4], 4'b0} + 4*w);
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        dirty_m.delete();
        gold   = dram;
        exp_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0; wr_en = '0; mem_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_outs", {miss, mem_rd_req, mem_wr_req, mem_addr}, 0);
    endtask

    task automatic access(input bit rd, input bit [3:0] be,
                          input bit [31:0] a, input bit [31:0] d,
                          input int lat);
        bit [2:0]  s = a[6:4];
        bit [24:0] t = a[31:7];
        bit [31:0] fill_a = {a[31:4], 4'b0};
        bit [31:0] ev_a = '0;
        bit        hit_e;
        bit        wb_e = 1'b0;
        bit [31:0] word;
        int        n;
        hit_e = (cnt[s] > 0 && mru_tag[s] == t) ||
                (cnt[s] == 2 && lru_tag[s] == t);
        if (!hit_e && cnt[s] == 2) begin
            ev_a = {lru_tag[s], s, 4'b0};
            wb_e = dirty_m.exists(ev_a) && dirty_m[ev_a];
        end
        @(negedge clk);
        rd_req = rd; wr_en = be; addr = a; wr_data = d;
        #1;
        chk("miss", miss, !hit_e);
        if (!hit_e) begin
            n = 0;
            while (!(mem_rd_req || mem_wr_req) && n < 4) begin
                @(negedge clk);
                n++;
            end
            if (wb_e) begin
                chk("wb_req", {mem_wr_req, mem_rd_req}, 2'b10);
                chk("wb_addr", mem_addr, ev_a);
                chk("wb_line", mem_wr_line, gold_line(ev_a));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                chk("wb_hold", {miss, mem_wr_req, mem_addr}, {2'b11, ev_a});
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                chk("wb_drop", {mem_wr_req, mem_rd_req}, 2'b01);
                for (int w = 0; w < 4; w++)
                    dram[(ev_a >> 2) + w] = gold_rd(ev_a + 4*w);
            end else begin
                chk("fill_req", {mem_wr_req, mem_rd_req}, 2'b01);
            end
            chk("fill_addr", mem_addr, fill_a);
            repeat (lat < 0 ? $urandom_range(0, 4) : lat) @(negedge clk);
            chk("fill_hold", {miss, mem_rd_req, mem_addr}, {2'b11, fill_a});
            mem_rd_line = dram_line(fill_a);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rd_line = {$urandom, $urandom, $urandom, $urandom};
            chk("fill_drop", {mem_wr_req, mem_rd_req, miss}, 3'b001);
            @(negedge clk);
            chk("miss_after_fill", miss, 0);
            if (cnt[s] > 0) lru_tag[s] = mru_tag[s];
            if (cnt[s] < 2) cnt[s]++;
            mru_tag[s] = t;
            dirty_m[fill_a] = 1'b0;
        end else if (mru_tag[s] != t) begin
            lru_tag[s] = mru_tag[s];
            mru_tag[s] = t;
        end
        if (be != 0) begin
            word = gold_rd(a);
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = d[8*b +: 8];
            gold[a >> 2] = word;
            dirty_m[fill_a] = 1'b1;
        end else begin
            exp_rd = gold_rd(a);
        end
        @(negedge clk);
        rd_req = 1'b0; wr_en = '0;
        #1;
        chk("rd_data", rd_data, exp_rd);
        chk("after_op", {mem_wr_req, mem_rd_req, miss}, 0);
    endtask

    initial begin
        bit [31:0] a;
        bit [3:0]  be;
        int        n;
        rst = 1'b1; rd_req = 1'b0; wr_en = '0; addr = '0; wr_data = '0;
        mem_gnt = 1'b0; mem_rd_line = '0;
        model_reset();
        do_reset();

        // cold read, byte write, dirty eviction
        access(1'b1, 4'b0000, 32'h10, 32'h0, 5);
        access(1'b0, 4'b0100, 32'h10, 32'h00AB0000, -1);
        access(1'b1, 4'b0000, 32'h10, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h90, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h110, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h90, 32'h0, -1);

        // clean eviction keeps the recently used line
        do_reset();
        access(1'b1, 4'b0000, 32'h10, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h90, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h10, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h110, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h14, 32'h0, -1);
        access(1'b1, 4'b0000, 32'h98, 32'h0, -1);

        // reset during a fill discards dirty data
        do_reset();
        access(1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, -1);
        @(negedge clk);
        rd_req = 1'b1; wr_en = '0; addr = 32'h310;
        #1;
        chk("pre_rst_miss", miss, 1);
        n = 0;
        while (!mem_rd_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_fill", mem_rd_req, 1);
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst", {mem_rd_req, mem_wr_req, miss}, 0);
        chk("mid_rst_rd", rd_data, 0);
        model_reset();
        access(1'b1, 4'b0000, 32'h10, 32'h0, -1);

        // idle hold with stray grants
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_gnt = (i % 3 == 1);
            #1;
            chk("idle", {miss, mem_rd_req, mem_wr_req, rd_data},
                {3'b000, exp_rd});
        end
        mem_gnt = 1'b0;

        for (int i = 0; i < 250; i++) begin
            a  = {25'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 2'b00};
            be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            access((be == 0) ? 1'b1 : 1'($urandom_range(0, 1)), be, a,
                   $urandom, -1);
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
